modport_slave: RTL and testbench



---
 rtl/modport_slave_pkg.sv | 11 +
 rtl/modport_slave_if.sv | 31 +++
 rtl/modport_slave_regfile.sv | 32 +++
 rtl/modport_slave.sv | 107 ++++++++++
 tb/tb_modport_slave.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/modport_slave_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes, bus widths and the slave write-channel state type
package axi_lite_pkg;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = 4;
  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;
  typedef enum logic [2:0] {WR_IDLE, WR_AW, WR_W, WR_BOTH, WR_RESP} wr_state_t;
endpackage

// File: rtl/modport_slave_if.sv
// modport_slave_if: AXI4-Lite bus bundle with master and slave views
interface modport_slave_if #(parameter int ADDR_WIDTH = 32);
  import axi_lite_pkg::*;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  resp_t                     bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  resp_t                     rresp;
  logic                      rvalid;
  logic                      rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/modport_slave_regfile.sv
// modport_slave_regfile: NUM_REGS x 32-bit registers with a byte-strobed write port, one async read port and a flat view
module modport_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_we,
  input  logic [$clog2(NUM_REGS)-1:0]            i_widx,
  input  logic [AXI_DATA_WIDTH-1:0]              i_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]              i_wstrb,
  input  logic [$clog2(NUM_REGS)-1:0]            i_ridx,
  output logic [AXI_DATA_WIDTH-1:0]              o_rdata,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]     o_reg_out
);
  logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
  // byte-enabled register update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else if (i_we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++)
        if (i_wstrb[b]) r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end
  assign o_rdata = r_regs[i_ridx];
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_reg_out[AXI_DATA_WIDTH*k +: AXI_DATA_WIDTH] = r_regs[k];
  end
endmodule

// File: rtl/modport_slave.sv
// modport_slave: AXI4-Lite slave register bank exposing every register on a flat output bus
module modport_slave
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                               aclk,
  input  logic                               areset,
  modport_slave_if.slave                     s_axi,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS*4);
  wr_state_t                 r_state, w_next;
  logic [ADDR_WIDTH-1:0]     r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata, r_rdata, w_rd_reg;
  logic [AXI_STRB_WIDTH-1:0] r_wstrb;
  resp_t                     r_bresp, r_rresp;
  logic                      r_rvalid;
  logic                      w_awready, w_wready, w_bvalid, w_commit;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_aw_ok, w_ar_ok;
  logic                      w_unused;
  assign w_aw_hs  = s_axi.awvalid && w_awready;
  assign w_w_hs   = s_axi.wvalid && w_wready;
  assign w_ar_hs  = s_axi.arvalid && !r_rvalid;
  assign w_aw_ok  = r_awaddr < SPAN;
  assign w_ar_ok  = s_axi.araddr < SPAN;
  assign w_unused = ^{s_axi.awprot, s_axi.arprot};
  // write-channel state register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= WR_IDLE;
    else r_state <= w_next;
  end
  // write-channel next state: collect AW and W in either order, commit, then wait for bready
  always_comb begin
    w_next = r_state;
    case (r_state)
      WR_IDLE: w_next = (w_aw_hs && w_w_hs) ? WR_BOTH : w_aw_hs ? WR_AW : w_w_hs ? WR_W : WR_IDLE;
      WR_AW:   w_next = w_w_hs ? WR_BOTH : WR_AW;
      WR_W:    w_next = w_aw_hs ? WR_BOTH : WR_W;
      WR_BOTH: w_next = WR_RESP;
      WR_RESP: w_next = s_axi.bready ? WR_IDLE : WR_RESP;
      default: w_next = WR_IDLE;
    endcase
  end
  // write-channel outputs decoded from state only, so ready never depends on valid
  always_comb begin
    w_awready = (r_state == WR_IDLE) || (r_state == WR_W);
    w_wready  = (r_state == WR_IDLE) || (r_state == WR_AW);
    w_bvalid  = r_state == WR_RESP;
    w_commit  = r_state == WR_BOTH;
  end
  // capture address/data on their handshakes and the response at commit
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      if (w_commit) r_bresp <= w_aw_ok ? OKAY : SLVERR;
    end
  end
  // read channel: register the response at the AR handshake, hold it until rready
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_ok ? w_rd_reg : '0;
      r_rresp  <= w_ar_ok ? OKAY : SLVERR;
    end else if (s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end
  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = !r_rvalid;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  modport_slave_regfile #(
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) u_regfile (
    .clk       (aclk),
    .rst       (areset),
    .i_we      (w_commit && w_aw_ok),
    .i_widx    (r_awaddr[2 +: IW]),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_wstrb),
    .i_ridx    (s_axi.araddr[2 +: IW]),
    .o_rdata   (w_rd_reg),
    .o_reg_out (reg_out)
  );
endmodule

// File: tb/tb_modport_slave.sv
// tb_modport_slave: directed table, corner sequences and random traffic against a word-array model
module tb_modport_slave;
  import axi_lite_pkg::*;
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'h0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          bd;
    int          rd;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;
  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [NR*32-1:0] reg_out;
  int              compared = 0;
  int              mismatched = 0;
  logic [31:0]     model [NR];
  vec_t            tbl [9];
  modport_slave_if #(.ADDR_WIDTH(32)) bus();
  modport_slave #(.ADDR_WIDTH(32), .NUM_REGS(NR), .RESET_VALUE(RV)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_axi   (bus),
    .reg_out (reg_out)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a >= NR*4) return SLVERR;
    for (int b = 0; b < 4; b++) if (s[b]) model[a/4][8*b +: 8] = d[8*b +: 8];
    return OKAY;
  endfunction
  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0;
    r = SLVERR;
    if (a < NR*4) begin
      d = model[a/4];
      r = OKAY;
    end
  endtask
  task automatic idle_bus();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
    bus.awprot = 0; bus.arprot = 0; bus.awaddr = 0; bus.araddr = 0; bus.wdata = 0; bus.wstrb = 0;
  endtask
  task automatic do_reset();
    idle_bus();
    areset = 1;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    for (int i = 0; i < NR; i++) model[i] = RV;
  endtask
  task automatic check_regs(input string nm);
    for (int i = 0; i < NR; i++) chk(nm, reg_out[32*i +: 32], model[i]);
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int bd, output logic [1:0] resp);
    bit ad = 0, wd = 0, ah, wh;
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(ad && wd) && n < 40) begin
      bus.awvalid = !ad && n >= aw_dly;
      bus.wvalid  = !wd && n >= w_dly;
      ah = bus.awvalid && bus.awready;
      wh = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      n++;
      ad |= ah;
      wd |= wh;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    chk("aw_w_accept", {31'b0, ad && wd}, 1);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("b_latency", n, 1);
    resp = bus.bresp;
    for (int i = 0; i < bd; i++) begin
      @(posedge aclk); #1;
      chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, resp});
      chk("aw_w_ready_low_during_b", {bus.awready, bus.wready}, 0);
    end
    bus.bready = 1;
    @(posedge aclk); #1;
    bus.bready = 0;
    chk("b_clear", bus.bvalid, 0);
  endtask
  task automatic axi_read(input logic [31:0] a, input int rd, output logic [31:0] d, output logic [1:0] r);
    bit h = 0;
    int n = 0;
    bus.araddr = a;
    bus.arvalid = 1;
    while (!h && n < 20) begin
      h = bus.arready;
      @(posedge aclk); #1;
      n++;
    end
    bus.arvalid = 0;
    chk("ar_accept", {31'b0, h}, 1);
    chk("r_latency", bus.rvalid, 1);
    d = bus.rdata;
    r = bus.rresp;
    for (int i = 0; i < rd; i++) begin
      @(posedge aclk); #1;
      chk("r_hold", {bus.rvalid, bus.rresp}, {1'b1, r});
      chk("r_data_hold", bus.rdata, d);
      chk("arready_low_during_r", bus.arready, 0);
    end
    bus.rready = 1;
    @(posedge aclk); #1;
    bus.rready = 0;
    chk("r_clear", bus.rvalid, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0]  resp, rr, er;
    logic [31:0] rdv, ed, a, d;
    logic [3:0]  s;
    tbl[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, OKAY,   32'hDEADBEEF, OKAY};
    tbl[1] = '{32'h08, 32'h11223344, 4'hF, 0, 0, 0, 0, OKAY,   32'h11223344, OKAY};
    tbl[2] = '{32'h08, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, OKAY,   32'h11BB33DD, OKAY};
    tbl[3] = '{32'h0C, 32'hCAFEF00D, 4'hF, 3, 0, 4, 0, OKAY,   32'hCAFEF00D, OKAY};
    tbl[4] = '{32'h40, 32'h12345678, 4'hF, 0, 0, 0, 0, SLVERR, 32'h00000000, SLVERR};
    tbl[5] = '{32'h0E, 32'h000000AA, 4'h1, 0, 1, 0, 3, OKAY,   32'hCAFEF0AA, OKAY};
    tbl[6] = '{32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, OKAY,   32'h00000000, OKAY};
    tbl[7] = '{32'h3C, 32'h5A5A5A5A, 4'hF, 0, 2, 1, 1, OKAY,   32'h5A5A5A5A, OKAY};
    tbl[8] = '{32'h3D, 32'h0000BB00, 4'h2, 1, 1, 0, 0, OKAY,   32'h5A5ABB5A, OKAY};
    do_reset();
    chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_valid", {bus.bvalid, bus.rvalid}, 0);
    chk("rst_resp", {bus.bresp, bus.rresp}, 0);
    chk("rst_rdata", bus.rdata, 0);
    check_regs("rst_reg_out");
    foreach (tbl[i]) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, tbl[i].bd, resp);
      chk("tbl_bresp", resp, tbl[i].exp_bresp);
      void'(model_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
      axi_read(tbl[i].addr, tbl[i].rd, rdv, rr);
      chk("tbl_rdata", rdv, tbl[i].exp_rdata);
      chk("tbl_rresp", rr, tbl[i].exp_rresp);
    end
    check_regs("tbl_reg_out");
    // read and write commit hitting register 3 on the same edge
    bus.awaddr = 32'h0C; bus.wdata = 32'h01020304; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    chk("rw_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 32'h0C; bus.arvalid = 1;
    @(posedge aclk); #1;
    bus.arvalid = 0;
    chk("rw_same_edge_rdata", bus.rdata, model[3]);
    chk("rw_same_edge_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    void'(model_write(32'h0C, 32'h01020304, 4'hF));
    chk("rw_same_edge_reg", reg_out[3*32 +: 32], model[3]);
    bus.bready = 1; bus.rready = 1;
    @(posedge aclk); #1;
    bus.bready = 0; bus.rready = 0;
    chk("rw_clear", {bus.bvalid, bus.rvalid}, 0);
    // reset after AW but before W discards the pending write
    bus.awaddr = 32'h04; bus.awvalid = 1;
    @(posedge aclk); #1;
    bus.awvalid = 0;
    areset = 1;
    @(posedge aclk); #1;
    areset = 0;
    for (int i = 0; i < NR; i++) model[i] = RV;
    chk("mid_rst_bvalid", bus.bvalid, 0);
    chk("mid_rst_ready", {bus.awready, bus.wready}, 2'b11);
    check_regs("mid_rst_regs");
    bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1;
    @(posedge aclk); #1;
    bus.wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("w_alone_no_b", bus.bvalid, 0);
    end
    check_regs("w_alone_regs");
    do_reset();
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 79));
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
        chk("rnd_bresp", resp, model_write(a, d, s));
      end else begin
        axi_read(a, $urandom_range(0, 2), rdv, rr);
        model_read(a, ed, er);
        chk("rnd_rdata", rdv, ed);
        chk("rnd_rresp", rr, er);
      end
    end
    check_regs("rnd_reg_out");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
